// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and default widths for the data-RAM arbiter.
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, LOCK1} arb_state_t;
    localparam int DMEM_ADDR_WIDTH = 10;
    localparam int DMEM_SIZE = 32;
endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// dmem_arb_starve_cnt: saturating counter of consecutive denied loader cycles.
module dmem_arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    assign sat = cnt == W'(LIMIT);
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !sat) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between core (port 0) and loader (port 1).
// DMEM_ARB_ROUND_ROBIN_EN swaps fixed priority + starvation counter for last-owner round robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DMEM_ADDR_WIDTH,
    parameter int SIZE         = DMEM_SIZE,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [SIZE-1:0]       p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [SIZE-1:0]       p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic                  p1_lock,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [SIZE-1:0]       p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [SIZE-1:0]       p1_rdata,
    output logic [ADDR_WIDTH-1:0] daddr,
    output logic                  mem0_ena_w,
    output logic [SIZE-1:0]       ddata_w,
    input  logic [SIZE-1:0]       ddata_r
);
    arb_state_t state, state_nx;
    logic in_lock, both, pick1;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [SIZE-1:0] wdata_q;

    assign both = p0_req & p1_req;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    assign pick1 = both ? state == OWN0 : p1_req;
`else
    logic starved;
    dmem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (p1_req & ~p1_gnt),
        .clr     (p1_gnt | ~p1_req),
        .sat     (starved)
    );
    assign pick1 = both ? starved : p1_req;
`endif

    // Grants are masked during reset so the RAM sees no access while RESET_N is low.
    always_comb begin
        in_lock  = state == LOCK1 && p1_lock;
        p1_gnt   = RESET_N & (in_lock ? p1_req : pick1);
        p0_gnt   = RESET_N & ~in_lock & p0_req & ~pick1;
        state_nx = (in_lock || (p1_gnt && p1_lock)) ? LOCK1 : p1_gnt ? OWN1 : p0_gnt ? OWN0 : IDLE;
    end

    assign daddr      = p0_gnt ? p0_addr : p1_gnt ? p1_addr : addr_q;
    assign ddata_w    = p0_gnt ? p0_wdata : p1_gnt ? p1_wdata : wdata_q;
    assign mem0_ena_w = (p0_gnt & p0_we) | (p1_gnt & p1_we);
    assign p0_rdata   = ddata_r;
    assign p1_rdata   = ddata_r;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            state     <= state_nx;
            addr_q    <= daddr;
            wdata_q   <= ddata_w;
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
        end
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: port 0 is the core data port and port 1 is the program loader / debug port.
- Sits between `main`/loader and `RAM`, and drives `daddr`, `mem0_ena_w` and `ddata_w`.
- Fixed priority goes to the core. A starvation counter guarantees loader progress, and a lock input lets the loader hold the RAM for a burst.

Parameters:
ADDR_WIDTH, 10, word address width of RAM and both ports
SIZE, 32, data width
STARVE_LIMIT, 4, consecutive denied port-1 request cycles before port 1 is forced to win (range 1..15)

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
p0_req  in  1  core access request
p0_we  in  1  core write enable (1 = write, 0 = read)
p0_addr  in  ADDR_WIDTH  core address
p0_wdata  in  SIZE  core write data
p0_gnt  out  1  core access performed this cycle
p0_rvalid  out  1  core read data valid (one cycle after a granted read)
p0_rdata  out  SIZE  core read data
p1_req  in  1  loader access request
p1_we  in  1  loader write enable
p1_lock  in  1  loader requests exclusive ownership
p1_addr  in  ADDR_WIDTH  loader address
p1_wdata  in  SIZE  loader write data
p1_gnt  out  1  loader access performed this cycle
p1_rvalid  out  1  loader read data valid
p1_rdata  out  SIZE  loader read data
daddr  out  ADDR_WIDTH  RAM address
mem0_ena_w  out  1  RAM write enable
ddata_w  out  SIZE  RAM write data
ddata_r  in  SIZE  RAM read data; synchronous, valid the cycle after daddr

Behaviour:
- Reset (async, RESET_N=0): all gnt/rvalid=0, mem0_ena_w=0, daddr=0, ddata_w=0, starve counter=0, state=IDLE. Any read in flight is dropped; no rvalid after reset release.
- Grant is combinational from req and registered state. The access is issued the same cycle.
- A requester holds req/we/addr/wdata stable until it sees gnt.
- RAM mux: daddr/ddata_w follow the granted port. With no grant, daddr holds its last value. mem0_ena_w = gnt_x & we_x, and is never 1 without a grant.
- Reads: pX_rvalid is registered and goes to 1 the cycle after a granted read (we=0). pX_rdata = ddata_r, and is only meaningful while rvalid=1. Writes never produce rvalid.
- Back-to-back grants are allowed every cycle; there is no bubble.
- States: IDLE, OWN0, OWN1, LOCK1 (the registered last owner).
  - IDLE/OWN0/OWN1, no lock:
    - Only one req → that port wins.
    - Both req → p0 wins unless starve_cnt == STARVE_LIMIT, then p1 wins.
    - Next state = winner's OWN state, or IDLE if there is no req.
  - Entry to LOCK1: p1 granted with p1_lock=1.
  - In LOCK1:
    - p0 is never granted.
    - p1 is granted whenever p1_req=1.
    - Exit to IDLE on the first cycle with p1_lock=0; that same cycle is arbitrated normally.
- Starve counter:
  - Width $clog2(STARVE_LIMIT+1).
  - Increments, saturating at STARVE_LIMIT, on each cycle p1_req=1 and p1_gnt=0.
  - Clears on p1_gnt or p1_req=0.
- p0 is not protected from starvation under lock; the loader only locks while the core is held in reset or stalled.
- p1_lock without p1_req in a non-LOCK1 state has no effect.

Optional Feature:
- Macro DMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - The fixed priority and starve counter are removed.
  - On simultaneous requests, the port that was not the last owner wins. From IDLE after reset, p0 wins.
  - Lock behaviour is unchanged.
- Undefined: fixed priority with the starvation counter, as above.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1, LOCK1} arb_state_t
  - default constants DMEM_ADDR_WIDTH=10, DMEM_SIZE=32
- Sub-module: dmem_arb_starve_cnt (saturating counter with clear), instantiated only when DMEM_ARB_ROUND_ROBIN_EN is undefined.
- The grant logic and RAM mux stay in the top module.

Test Plan:
- p0 write addr 5 = 0xDEADBEEF; next cycle p0 read addr 5 → p0_gnt both cycles; p0_rvalid=1 with p0_rdata=0xDEADBEEF one cycle after the read.
- p0_req and p1_req held high continuously, STARVE_LIMIT=4 → p0 wins 4 cycles; p1_gnt on cycle 5; counter clears; pattern repeats. With DMEM_ARB_ROUND_ROBIN_EN, grants alternate p0,p1,p0,...
- p1 writes addr 0..7 with p1_lock=1, p0_req high throughout → p1_gnt 8 consecutive cycles, p0_gnt=0. Drop lock → p0 granted next cycle.
- Both ports idle → gnt=0 and mem0_ena_w=0. Check that daddr holds its last value and that RAM contents are unchanged after 10 idle cycles.
- Reset asserted the cycle after a granted p1 read (addr 3) → all outputs 0 asynchronously; no p1_rvalid after release; state IDLE.
- Load a program through p1 while core p0 is in reset, then release → a core read of addr 0 returns the first loaded word.
